fwd_hazard_ctrl: RTL and testbench
==================================

# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the pipelined MIPS core. It sits between the ID/EX pipeline register and the EX operand muxes. It resolves operand sources one cycle early, in ID, and registers the forward selects into EX. It also detects load-use hazards and runs a stall FSM with a configurable number of stall cycles. The operand count is parametrised, and a register-file write-through bypass flag is added for ID.

## Interface
- REG_AW, 5, register address width.
- NSRC, 2, number of source operands per instruction (rs, rt, ...).
- LOAD_STALL, 1, stall cycles per load-use hazard, range 1..15.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pipe_hold  in  1  external freeze (e.g. cache miss); all state holds while high.
- ID_src  in  NSRC*REG_AW  ID-stage source register numbers; operand i is at bits [i*REG_AW +: REG_AW].
- ID_src_used  in  NSRC  per-operand "source actually read" flag.
- EX_RegWrite, EX_MemRead  in  1 each  controls of the instruction currently in EX.
- EX_WriteRegister  in  REG_AW  destination register of the instruction in EX.
- MEM_RegWrite  in  1  control of the instruction in MEM.
- MEM_WriteRegister  in  REG_AW  destination register of the instruction in MEM.
- WB_RegWrite  in  1  control of the instruction in WB.
- WB_WriteRegister  in  REG_AW  destination register of the instruction in WB.
- Forward  out  2*NSRC  registered EX-stage selects, 2 bits per operand: 10 = MEM result, 01 = WB result, 00 = register file.
- ID_bypass  out  NSRC  combinational; 1 = take this operand from WB write data in ID.
- PC_Write, IFID_Write  out  1 each  0 while stalling.
- IDEX_Flush  out  1  1 = insert a bubble into ID/EX.

## Operation
- A destination is "valid" when its RegWrite is 1 and the register number is nonzero. Register 0 never matches.
- Next-select per operand i, computed in ID:
  - 10 if ID_src_used[i] and EX dest valid, not a load, and equal to the source.
  - else 01 if used and MEM dest valid and equal.
  - else 00.
  - The younger producer always wins.
- A load in EX that matches a used source is never forwarded as 10; it is the load-use hazard (haz).
- ID_bypass[i] = used[i] and WB dest valid and WB_WriteRegister == source i.
- FSM states: IDLE and STALL, with a 4-bit counter cnt.
  - IDLE: stall = haz. If haz and LOAD_STALL > 1, go to STALL with cnt = LOAD_STALL-1.
  - STALL: stall = 1 and cnt decrements. Return to IDLE in the cycle cnt == 1, which is the last stall cycle.
- While stall is 1: PC_Write = 0, IFID_Write = 0, IDEX_Flush = 1.
- Forward register update:
  - Normal advance: loads the next-selects.
  - Stall: loads 00 (bubble).
  - pipe_hold = 1: no update.
- pipe_hold = 1 freezes the FSM state, cnt and Forward, and forces PC_Write = IFID_Write = 0, IDEX_Flush = 0. Hold has priority over stall.
- A hazard seen during STALL is not re-evaluated; it is re-checked in IDLE once the FSM returns.

## Timing
- Reset values: Forward = 0, state = IDLE, cnt = 0, PC_Write = 1, IFID_Write = 1, IDEX_Flush = 0.
- Reset mid-stall: the FSM returns to IDLE on the next edge. Reset overrides pipe_hold.
- Forward latency: one edge from ID compare to EX use.
- ID_bypass, PC_Write, IFID_Write and IDEX_Flush are combinational from the current inputs and state.
- Stall length: exactly LOAD_STALL cycles per hazard, excluding any pipe_hold cycles.
- LOAD_STALL = 1: the FSM never leaves IDLE.
- The stall window is followed by at least one issue cycle unless a new hazard or hold appears.

## Configuration
- FWD_STATS_EN defined:
  - Adds outputs stall_cycles[15:0] and fwd_events[15:0].
  - Both are saturating counters, cleared by reset, frozen by pipe_hold.
  - stall_cycles increments per cycle with stall = 1.
  - fwd_events increments per non-stall, non-hold cycle in which any next-select is nonzero.
- FWD_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- EX add writes r3, ID uses r3 as src0 -> next cycle Forward[1:0] = 10, no stall.
- MEM writes r3 and EX writes r3, ID reads r3 -> Forward = 10 (younger wins). With the EX write removed -> 01.
- EX lw writes r5, ID reads r5, LOAD_STALL = 3:
  - IDEX_Flush = 1 and PC_Write = 0 for exactly 3 cycles.
  - Forward = 00 during the stall.
  - Issue in the 4th cycle with ID_bypass set.
- Any stage writing r0, or ID_src_used = 0 -> Forward = 00, ID_bypass = 0, no stall.
- pipe_hold = 1 for 2 cycles mid-stall -> cnt, state and Forward frozen; total stall is still LOAD_STALL non-hold cycles.
- reset asserted in the 2nd of 3 stall cycles -> next cycle all outputs at reset values; with FWD_STATS_EN, stall_cycles = 0.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
// Forwarding and load-use hazard controller for the pipelined MIPS core.
// Operand sources are resolved in ID and registered into EX as Forward
// selects. A load in EX feeding a used ID source triggers a stall of
// LOAD_STALL cycles.
//
// Optional feature: define FWD_STATS_EN to add the saturating counters
// stall_cycles and fwd_events.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pipe_hold           external freeze, has priority over stall
//   ID_src, ID_src_used ID source register numbers and per-operand read flags
//   EX_/MEM_/WB_*       producer controls and destinations per stage
//   Forward             registered EX selects (10 MEM, 01 WB, 00 regfile)
//   ID_bypass           combinational WB write-through flag per operand
//   PC_Write, IFID_Write, IDEX_Flush  combinational stall controls
//   stall_cycles, fwd_events          (FWD_STATS_EN only) statistics
//
// state | meaning
// IDLE  | normal issue; a load-use hazard stalls this cycle
// STALL | remaining stall cycles of a multi-cycle load-use stall, cnt counts down

module fwd_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int NSRC       = 2,
  parameter int LOAD_STALL = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_hold,
  input  logic [NSRC*REG_AW-1:0]   ID_src,
  input  logic [NSRC-1:0]          ID_src_used,
  input  logic                     EX_RegWrite,
  input  logic                     EX_MemRead,
  input  logic [REG_AW-1:0]        EX_WriteRegister,
  input  logic                     MEM_RegWrite,
  input  logic [REG_AW-1:0]        MEM_WriteRegister,
  input  logic                     WB_RegWrite,
  input  logic [REG_AW-1:0]        WB_WriteRegister,
  output logic [2*NSRC-1:0]        Forward,
  output logic [NSRC-1:0]          ID_bypass,
  output logic                     PC_Write,
  output logic                     IFID_Write,
  output logic                     IDEX_Flush
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]              stall_cycles,
  output logic [15:0]              fwd_events
`endif
);

  typedef enum logic {IDLE, STALL} stateT;

  localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL - 1);

  stateT             state;
  logic [3:0]        cnt;
  logic [2*NSRC-1:0] nextSel;
  logic              haz;
  logic              stall;
  logic              exValid, memValid, wbValid;
  logic [REG_AW-1:0] src;

  assign exValid  = EX_RegWrite  && (EX_WriteRegister  != '0);
  assign memValid = MEM_RegWrite && (MEM_WriteRegister != '0);
  assign wbValid  = WB_RegWrite  && (WB_WriteRegister  != '0);

  always_comb begin
    nextSel   = '0;
    ID_bypass = '0;
    haz       = 1'b0;
    src       = '0;
    for (int i = 0; i < NSRC; i++) begin
      src = ID_src[i*REG_AW +: REG_AW];
      if (ID_src_used[i]) begin
        // A matching load in EX cannot be forwarded; it becomes the hazard
        // and the MEM producer (if any) is still considered as the select.
        if (exValid && EX_MemRead && (EX_WriteRegister == src))
          haz = 1'b1;
        if (exValid && !EX_MemRead && (EX_WriteRegister == src))
          nextSel[2*i +: 2] = 2'b10;
        else if (memValid && (MEM_WriteRegister == src))
          nextSel[2*i +: 2] = 2'b01;
        if (wbValid && (WB_WriteRegister == src))
          ID_bypass[i] = 1'b1;
      end
    end
  end

  // Hazards are only evaluated in IDLE; during STALL the window runs out.
  assign stall      = (state == STALL) || haz;
  assign PC_Write   = !pipe_hold && !stall;
  assign IFID_Write = !pipe_hold && !stall;
  assign IDEX_Flush = !pipe_hold && stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      Forward <= '0;
      state   <= IDLE;
      cnt     <= '0;
    end else if (!pipe_hold) begin
      Forward <= stall ? '0 : nextSel;
      case (state)
        IDLE: begin
          if (haz && (LOAD_STALL > 1)) begin
            state <= STALL;
            cnt   <= STALL_INIT;
          end
        end
        STALL: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef FWD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else if (!pipe_hold) begin
      if (stall && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if (!stall && (nextSel != '0) && (fwd_events != 16'hFFFF))
        fwd_events <= fwd_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       pipe_hold;
  logic [9:0] ID_src;
  logic [1:0] ID_src_used;
  logic       EX_RegWrite, EX_MemRead;
  logic [4:0] EX_WriteRegister;
  logic       MEM_RegWrite;
  logic [4:0] MEM_WriteRegister;
  logic       WB_RegWrite;
  logic [4:0] WB_WriteRegister;

  logic [3:0] Forward, fwd1;
  logic [1:0] ID_bypass, byp1;
  logic       PC_Write, IFID_Write, IDEX_Flush;
  logic       pc1, ifid1, fl1;
`ifdef FWD_STATS_EN
  logic [15:0] stall_cycles, fwd_events, sc1, fe1;
`endif

  fwd_hazard_ctrl #(.REG_AW(5), .NSRC(2), .LOAD_STALL(3)) dut (
    .clk(clk), .reset(reset), .pipe_hold(pipe_hold),
    .ID_src(ID_src), .ID_src_used(ID_src_used),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister),
    .MEM_RegWrite(MEM_RegWrite), .MEM_WriteRegister(MEM_WriteRegister),
    .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister),
    .Forward(Forward), .ID_bypass(ID_bypass),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Flush(IDEX_Flush)
`ifdef FWD_STATS_EN
    , .stall_cycles(stall_cycles), .fwd_events(fwd_events)
`endif
  );

  fwd_hazard_ctrl #(.REG_AW(5), .NSRC(2), .LOAD_STALL(1)) dut1 (
    .clk(clk), .reset(reset), .pipe_hold(pipe_hold),
    .ID_src(ID_src), .ID_src_used(ID_src_used),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister),
    .MEM_RegWrite(MEM_RegWrite), .MEM_WriteRegister(MEM_WriteRegister),
    .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister),
    .Forward(fwd1), .ID_bypass(byp1),
    .PC_Write(pc1), .IFID_Write(ifid1), .IDEX_Flush(fl1)
`ifdef FWD_STATS_EN
    , .stall_cycles(sc1), .fwd_events(fe1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0] s0, s1;
    logic [1:0] used;
    logic       exRw, exMr;
    logic [4:0] exWr;
    logic       memRw;
    logic [4:0] memWr;
    logic       wbRw;
    logic [4:0] wbWr;
    logic [3:0] eF;
    logic [1:0] eB;
  } vecT;

  vecT        vecs[11];
  logic [3:0] expQ[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic setIn(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                       input logic exRw, input logic exMr, input logic [4:0] exWr,
                       input logic memRw, input logic [4:0] memWr,
                       input logic wbRw, input logic [4:0] wbWr);
    ID_src            = {s1, s0};
    ID_src_used       = used;
    EX_RegWrite       = exRw;
    EX_MemRead        = exMr;
    EX_WriteRegister  = exWr;
    MEM_RegWrite      = memRw;
    MEM_WriteRegister = memWr;
    WB_RegWrite       = wbRw;
    WB_WriteRegister  = wbWr;
  endtask

  // Checks combinational outputs for the current cycle, queues the Forward
  // value expected after the edge, then compares it once the edge has passed.
  task automatic step(input logic [3:0] eF, input logic eP, input logic eFl,
                      input logic [1:0] eB, input string nm);
    #1;
    chk({nm, " pc"}, PC_Write, eP);
    chk({nm, " ifid"}, IFID_Write, eP);
    chk({nm, " flush"}, IDEX_Flush, eFl);
    chk({nm, " bypass"}, ID_bypass, eB);
    expQ.push_back(eF);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s fwd scoreboard empty", nm);
    end else begin
      chk({nm, " fwd"}, Forward, expQ.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    //            s0     s1     used   exRw  exMr  exWr   memRw memWr  wbRw  wbWr   eF       eB
    vecs[0]  = '{5'd3, 5'd7, 2'b11, 1'b1, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0010, 2'b00};
    vecs[1]  = '{5'd3, 5'd7, 2'b11, 1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 4'b0010, 2'b00};
    vecs[2]  = '{5'd3, 5'd7, 2'b11, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 4'b0001, 2'b00};
    vecs[3]  = '{5'd0, 5'd0, 2'b11, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 4'b0000, 2'b00};
    vecs[4]  = '{5'd3, 5'd3, 2'b00, 1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 4'b0000, 2'b00};
    vecs[5]  = '{5'd4, 5'd9, 2'b11, 1'b1, 1'b0, 5'd9, 1'b1, 5'd4, 1'b0, 5'd0, 4'b1001, 2'b00};
    vecs[6]  = '{5'd6, 5'd6, 2'b11, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 4'b0000, 2'b11};
    vecs[7]  = '{5'd6, 5'd6, 2'b10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 4'b0000, 2'b10};
    vecs[8]  = '{5'd1, 5'd3, 2'b11, 1'b0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 4'b0100, 2'b00};
    vecs[9]  = '{5'd5, 5'd6, 2'b10, 1'b1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 5'd0, 4'b0100, 2'b00};
    vecs[10] = '{5'd2, 5'd2, 2'b01, 1'b1, 1'b0, 5'd2, 1'b1, 5'd2, 1'b1, 5'd2, 4'b0010, 2'b01};

    reset     = 1'b1;
    pipe_hold = 1'b0;
    setIn(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    chk("reset fwd", Forward, 4'b0000);
    chk("reset pc", PC_Write, 1'b1);
    chk("reset ifid", IFID_Write, 1'b1);
    chk("reset flush", IDEX_Flush, 1'b0);
`ifdef FWD_STATS_EN
    chk("reset stall_cycles", stall_cycles, 16'd0);
    chk("reset fwd_events", fwd_events, 16'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      setIn(vecs[i].s0, vecs[i].s1, vecs[i].used, vecs[i].exRw, vecs[i].exMr, vecs[i].exWr,
            vecs[i].memRw, vecs[i].memWr, vecs[i].wbRw, vecs[i].wbWr);
      step(vecs[i].eF, 1'b1, 1'b0, vecs[i].eB, $sformatf("vec%0d", i));
    end

    // Load-use with LOAD_STALL = 3, and LOAD_STALL = 1 instance alongside.
    setIn(5'd5, 5'd0, 2'b01, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("ls1 haz flush", fl1, 1'b1);
    chk("ls1 haz pc", pc1, 1'b0);
    step(4'b0000, 1'b0, 1'b1, 2'b00, "ldA1");
    setIn(5'd5, 5'd0, 2'b01, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
    #1;
    chk("ls1 after flush", fl1, 1'b0);
    chk("ls1 after pc", pc1, 1'b1);
    step(4'b0000, 1'b0, 1'b1, 2'b00, "ldA2");
    setIn(5'd5, 5'd0, 2'b01, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
    step(4'b0000, 1'b0, 1'b1, 2'b01, "ldA3");
    step(4'b0000, 1'b1, 1'b0, 2'b01, "ldA4");

    // Hold for two cycles in the middle of a stall.
    setIn(5'd3, 5'd0, 2'b01, 1'b1, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    step(4'b0010, 1'b1, 1'b0, 2'b00, "holdB0");
    setIn(5'd5, 5'd0, 2'b01, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    step(4'b0000, 1'b0, 1'b1, 2'b00, "holdB1");
    pipe_hold = 1'b1;
    setIn(5'd3, 5'd0, 2'b01, 1'b1, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    step(4'b0000, 1'b0, 1'b0, 2'b00, "holdB2");
    step(4'b0000, 1'b0, 1'b0, 2'b00, "holdB3");
    pipe_hold = 1'b0;
    setIn(5'd5, 5'd0, 2'b01, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    step(4'b0000, 1'b0, 1'b1, 2'b00, "holdB4");
    step(4'b0000, 1'b0, 1'b1, 2'b00, "holdB5");
    setIn(5'd3, 5'd0, 2'b01, 1'b1, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    step(4'b0010, 1'b1, 1'b0, 2'b00, "holdB6");

    // Hold freezes a nonzero Forward.
    pipe_hold = 1'b1;
    setIn(5'd3, 5'd0, 2'b01, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0);
    step(4'b0010, 1'b0, 1'b0, 2'b00, "holdC1");
    pipe_hold = 1'b0;
    step(4'b0001, 1'b1, 1'b0, 2'b00, "holdC2");

    // Reset in the second stall cycle, asserted together with hold.
    setIn(5'd5, 5'd0, 2'b01, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    step(4'b0000, 1'b0, 1'b1, 2'b00, "rstD1");
    reset     = 1'b1;
    pipe_hold = 1'b1;
    step(4'b0000, 1'b0, 1'b0, 2'b00, "rstD2");
    reset     = 1'b0;
    pipe_hold = 1'b0;
`ifdef FWD_STATS_EN
    chk("rstD stall_cycles", stall_cycles, 16'd0);
`endif
    setIn(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    step(4'b0000, 1'b1, 1'b0, 2'b00, "rstD3");

    // Reset clears a nonzero Forward even under hold.
    setIn(5'd3, 5'd0, 2'b01, 1'b1, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    step(4'b0010, 1'b1, 1'b0, 2'b00, "rstE1");
    reset     = 1'b1;
    pipe_hold = 1'b1;
    step(4'b0000, 1'b0, 1'b0, 2'b00, "rstE2");
    reset     = 1'b0;
    pipe_hold = 1'b0;
    setIn(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    step(4'b0000, 1'b1, 1'b0, 2'b00, "rstE3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
